// File: rtl/fifo_wr_traffic_gen.sv
// Programmable write-side traffic source for the async FIFO (wclk domain).
// Bursts of incrementing or LFSR data with word/burst gaps and wfull back-pressure.
module fifo_wr_traffic_gen #(
  parameter int unsigned DATASIZE  = 8,
  parameter int unsigned GAP_W     = 4,
  parameter int unsigned BURST_W   = 11,
  parameter int unsigned CNT_W     = 32,
  parameter logic [31:0] LFSR_SEED = 32'hACE1_0001
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic                start,
  input  logic                pattern_sel,
  input  logic [BURST_W-1:0]  burst_len,
  input  logic [BURST_W-1:0]  num_bursts,
  input  logic [GAP_W-1:0]    word_gap,
  input  logic [GAP_W-1:0]    burst_gap,
  input  logic                wfull,
  output logic                winc,
  output logic [DATASIZE-1:0] wdata,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    words_sent
);

  typedef enum logic [2:0] {IDLE, WRITE, WGAP, BGAP, DONE} state_t;

  // Galois right-shift mask for x^32 + x^22 + x^2 + x + 1
  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

  state_t               state, state_nxt;
  logic                 pat_q;
  logic [BURST_W-1:0]   blen_q, nbur_q;
  logic [GAP_W-1:0]     wgap_q, bgap_q;
  logic [BURST_W-1:0]   beat_cnt, burst_cnt;
  logic [BURST_W-1:0]   beat_inc, burst_inc;
  logic [GAP_W-1:0]     gap_cnt;
  logic [31:0]          lfsr, lfsr_step;
  logic                 accept, last_beat, last_burst;

  assign winc       = (state == WRITE);
  assign busy       = (state == WRITE) || (state == WGAP) || (state == BGAP);
  assign done       = (state == DONE);
  assign accept     = winc && !wfull;
  assign beat_inc   = beat_cnt + 1'b1;
  assign burst_inc  = burst_cnt + 1'b1;
  assign last_beat  = (beat_inc == blen_q);
  assign last_burst = (burst_inc == nbur_q);
  assign lfsr_step  = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? LFSR_MASK : '0);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          if ((burst_len == '0) || (num_bursts == '0)) state_nxt = DONE;
          else                                         state_nxt = WRITE;
        end
      end
      WRITE: begin
        if (accept) begin
          if (last_beat) begin
            if (last_burst)            state_nxt = DONE;
            else if (bgap_q != '0)     state_nxt = BGAP;
            else                       state_nxt = WRITE;
          end else if (wgap_q != '0)   state_nxt = WGAP;
          else                         state_nxt = WRITE;
        end
      end
      WGAP, BGAP: begin
        if (gap_cnt == '0) state_nxt = WRITE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state      <= IDLE;
      wdata      <= '0;
      words_sent <= '0;
      lfsr       <= LFSR_SEED;
      pat_q      <= 1'b0;
      blen_q     <= '0;
      nbur_q     <= '0;
      wgap_q     <= '0;
      bgap_q     <= '0;
      beat_cnt   <= '0;
      burst_cnt  <= '0;
      gap_cnt    <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            pat_q      <= pattern_sel;
            blen_q     <= burst_len;
            nbur_q     <= num_bursts;
            wgap_q     <= word_gap;
            bgap_q     <= burst_gap;
            words_sent <= '0;
            beat_cnt   <= '0;
            burst_cnt  <= '0;
            lfsr       <= LFSR_SEED;
            wdata      <= pattern_sel ? LFSR_SEED[DATASIZE-1:0] : '0;
          end
        end
        WRITE: begin
          if (accept) begin
            words_sent <= words_sent + 1'b1;
            lfsr       <= lfsr_step;
            wdata      <= pat_q ? lfsr_step[DATASIZE-1:0] : wdata + 1'b1;
            // Gap counter preloaded to gap-1 so the gap state lasts exactly gap cycles
            if (last_beat) begin
              beat_cnt  <= '0;
              burst_cnt <= burst_inc;
              gap_cnt   <= bgap_q - 1'b1;
            end else begin
              beat_cnt  <= beat_inc;
              gap_cnt   <= wgap_q - 1'b1;
            end
          end
        end
        WGAP, BGAP: begin
          if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_traffic_gen.sv
// Directed bench for fifo_wr_traffic_gen: scoreboard of expected write data plus
// per-cycle winc trace compared against a gap/burst model.
module tb_fifo_wr_traffic_gen;

  localparam int unsigned DATASIZE = 8;
  localparam int unsigned GAP_W    = 4;
  localparam int unsigned BURST_W  = 11;
  localparam int unsigned CNT_W    = 32;
  localparam logic [31:0] SEED     = 32'hACE1_0001;

  logic                wclk = 1'b0;
  logic                wrst_n;
  logic                start;
  logic                pattern_sel;
  logic [BURST_W-1:0]  burst_len, num_bursts;
  logic [GAP_W-1:0]    word_gap, burst_gap;
  logic                wfull;
  logic                winc;
  logic [DATASIZE-1:0] wdata;
  logic                busy, done;
  logic [CNT_W-1:0]    words_sent;

  fifo_wr_traffic_gen #(
    .DATASIZE (DATASIZE),
    .GAP_W    (GAP_W),
    .BURST_W  (BURST_W),
    .CNT_W    (CNT_W),
    .LFSR_SEED(SEED)
  ) dut (
    .wclk       (wclk),
    .wrst_n     (wrst_n),
    .start      (start),
    .pattern_sel(pattern_sel),
    .burst_len  (burst_len),
    .num_bursts (num_bursts),
    .word_gap   (word_gap),
    .burst_gap  (burst_gap),
    .wfull      (wfull),
    .winc       (winc),
    .wdata      (wdata),
    .busy       (busy),
    .done       (done),
    .words_sent (words_sent)
  );

  always #5 wclk = ~wclk;

  int checks   = 0;
  int failures = 0;
  int acc_cnt  = 0;
  int done_cnt = 0;
  int run_d0   = 0;
  logic [DATASIZE-1:0] exp_q[$];
  bit trace[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lstep(input logic [31:0] s);
    logic [31:0] n;
    n = '0;
    for (int i = 0; i < 31; i++) n[i] = s[i+1];
    n[31] = s[0];
    n[21] = n[21] ^ s[0];
    n[1]  = n[1]  ^ s[0];
    n[0]  = n[0]  ^ s[0];
    return n;
  endfunction

  // Scoreboard: every accepted word is popped and compared
  always @(negedge wclk) begin
    if (wrst_n) begin
      trace.push_back(winc);
      if (done) done_cnt++;
      if (winc && !wfull) begin
        acc_cnt++;
        check("word_expected", {63'b0, exp_q.size() != 0}, 64'd1);
        if (exp_q.size() != 0) check("wdata", {56'b0, wdata}, {56'b0, exp_q.pop_front()});
      end
    end
  end

  task automatic push_inc(input int first, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(DATASIZE'(first + i));
  endtask

  task automatic run(input bit pat, input int bl, input int nb, input int wg, input int bg,
                     input int stall_at, input int stall_len, input int xstart_at,
                     output int cyc);
    int  acc0;
    bit  stalled;
    pattern_sel = pat;
    burst_len   = BURST_W'(bl);
    num_bursts  = BURST_W'(nb);
    word_gap    = GAP_W'(wg);
    burst_gap   = GAP_W'(bg);
    @(posedge wclk); #1 start = 1'b1;
    @(posedge wclk); #1 start = 1'b0;
    trace.delete();
    acc0    = acc_cnt;
    run_d0  = done_cnt;
    stalled = 1'b0;
    cyc     = 0;
    while (done_cnt == run_d0 && cyc < 3000) begin
      @(posedge wclk); #1;
      cyc++;
      if (cyc == xstart_at)     start = 1'b1;
      if (cyc == xstart_at + 1) start = 1'b0;
      if (stall_len > 0 && !stalled && (acc_cnt - acc0) == stall_at) begin
        wfull = 1'b1;
        for (int s = 0; s < stall_len; s++) begin
          @(posedge wclk); #1;
          check("stall_winc", {63'b0, winc}, 64'd1);
          check("stall_wdata", {56'b0, wdata}, {56'b0, exp_q[0]});
        end
        wfull   = 1'b0;
        stalled = 1'b1;
      end
    end
    start = 1'b0;
    check("run_finished", {63'b0, done_cnt != run_d0}, 64'd1);
  endtask

  task automatic post_checks(input int words);
    repeat (3) @(posedge wclk);
    #1;
    check("done_pulses", 64'(done_cnt - run_d0), 64'd1);
    check("busy_after", {63'b0, busy}, 64'd0);
    check("words_sent", 64'(words_sent), 64'(words));
    check("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_trace(input int bl, input int nb, input int wg, input int bg);
    bit exp[$];
    if (bl != 0 && nb != 0) begin
      for (int b = 0; b < nb; b++) begin
        for (int w = 0; w < bl; w++) begin
          exp.push_back(1'b1);
          if (w != bl - 1) for (int g = 0; g < wg; g++) exp.push_back(1'b0);
        end
        if (b != nb - 1) for (int g = 0; g < bg; g++) exp.push_back(1'b0);
      end
    end
    exp.push_back(1'b0);
    check("trace_len", {63'b0, trace.size() >= exp.size()}, 64'd1);
    for (int i = 0; i < exp.size() && i < trace.size(); i++)
      check($sformatf("trace[%0d]", i), {63'b0, trace[i]}, {63'b0, exp[i]});
  endtask

  initial begin
    int cyc;
    int n;
    int acc0;
    logic [31:0] s;
    wrst_n = 1'b0; start = 1'b0; pattern_sel = 1'b0; wfull = 1'b0;
    burst_len = '0; num_bursts = '0; word_gap = '0; burst_gap = '0;
    repeat (3) @(posedge wclk);
    #1;
    check("rst_winc", {63'b0, winc}, 64'd0);
    check("rst_wdata", {56'b0, wdata}, 64'd0);
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_done", {63'b0, done}, 64'd0);
    check("rst_words", 64'(words_sent), 64'd0);
    wrst_n = 1'b1;

    // 1: incrementing, back-to-back words, burst gap 3
    push_inc(0, 8);
    run(1'b0, 4, 2, 0, 3, 0, 0, -10, cyc);
    check_trace(4, 2, 0, 3);
    post_checks(8);

    // 2: word gap 2
    push_inc(0, 8);
    run(1'b0, 4, 2, 2, 3, 0, 0, -10, cyc);
    check_trace(4, 2, 2, 3);
    post_checks(8);

    // 3: wfull stall after the 2nd accept
    push_inc(0, 6);
    run(1'b0, 6, 1, 0, 0, 2, 5, -10, cyc);
    post_checks(6);

    // 4: LFSR pattern, twice
    for (int r = 0; r < 2; r++) begin
      s = SEED;
      for (int i = 0; i < 3; i++) begin
        exp_q.push_back(s[DATASIZE-1:0]);
        s = lstep(s);
      end
      run(1'b1, 3, 1, 1, 0, 0, 0, -10, cyc);
      check_trace(3, 1, 1, 0);
      post_checks(3);
    end

    // 5a: burst_len 0
    run(1'b0, 0, 3, 0, 0, 0, 0, -10, cyc);
    check("degenerate_latency", {63'b0, cyc <= 2}, 64'd1);
    check_trace(0, 3, 0, 0);
    post_checks(0);

    // 5b: start pulsed while busy
    push_inc(0, 6);
    run(1'b0, 3, 2, 1, 1, 0, 0, 4, cyc);
    check_trace(3, 2, 1, 1);
    post_checks(6);

    // 6: reset mid-burst after 3 accepts
    push_inc(0, 3);
    pattern_sel = 1'b0; burst_len = BURST_W'(8); num_bursts = BURST_W'(1);
    word_gap = '0; burst_gap = '0;
    @(posedge wclk); #1 start = 1'b1;
    @(posedge wclk); #1 start = 1'b0;
    acc0 = acc_cnt - 0;
    n = 0;
    while ((acc_cnt - acc0) < 3 && n < 100) begin
      @(posedge wclk); #1;
      n++;
    end
    check("reach_3_accepts", 64'(acc_cnt - acc0), 64'd3);
    wrst_n = 1'b0;
    #1;
    check("mid_rst_winc", {63'b0, winc}, 64'd0);
    check("mid_rst_wdata", {56'b0, wdata}, 64'd0);
    check("mid_rst_busy", {63'b0, busy}, 64'd0);
    check("mid_rst_done", {63'b0, done}, 64'd0);
    check("mid_rst_words", 64'(words_sent), 64'd0);
    check("mid_rst_queue", 64'(exp_q.size()), 64'd0);
    @(posedge wclk); #1 wrst_n = 1'b1;
    push_inc(0, 2);
    run(1'b0, 2, 1, 0, 0, 0, 0, -10, cyc);
    check_trace(2, 1, 0, 0);
    post_checks(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
